axi_wr_burst_checker: RTL and testbench

Parametrised next-generation passive monitor for an AXI write interface (AW/W/B), instantiated beside the store-buffer master in the bench and in debug builds.
- Tracks outstanding bursts, using AWLEN to check WLAST placement.
- Detects stalls with a configurable timeout and matches B responses to completed bursts.
- Reports errors as a registered pulse plus a sticky first-error code and a saturating error counter.

---
 rtl/axi_chk_pkg.sv | 36 +++
 rtl/axi_chk_stall_timer.sv | 38 +++
 rtl/axi_wr_burst_checker.sv | 192 +++++++++++++++++++
 tb/tb_axi_wr_burst_checker.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_chk_pkg
// Brief    : Error codes and priority selection for axi_wr_burst_checker.
// Revision : 1.0
// ============================================================================
package axi_chk_pkg;

  localparam logic [3:0] ERR_NONE          = 4'h0;
  localparam logic [3:0] ERR_AW_STALL      = 4'h1;
  localparam logic [3:0] ERR_W_STALL       = 4'h2;
  localparam logic [3:0] ERR_B_STALL       = 4'h3;
  localparam logic [3:0] ERR_WLAST_EARLY   = 4'h4;
  localparam logic [3:0] ERR_WLAST_MISSING = 4'h5;
  localparam logic [3:0] ERR_EXOKAY        = 4'h6;
  localparam logic [3:0] ERR_W_NO_AW       = 4'h7;
  localparam logic [3:0] ERR_B_NO_BURST    = 4'h8;
  localparam logic [3:0] ERR_AW_OVERFLOW   = 4'h9;
  localparam logic [3:0] ERR_AW_UNSTABLE   = 4'hA;
  localparam logic [3:0] ERR_W_UNSTABLE    = 4'hB;
  localparam logic [3:0] ERR_VALID_DROP    = 4'hC;

  localparam int ERR_MAX = 12;

  // Bit i of vec flags error code i; the lowest flagged code is reported.
  function automatic logic [3:0] err_pick(input logic [ERR_MAX:1] vec);
    logic [3:0] code;
    code = ERR_NONE;
    for (int i = ERR_MAX; i >= 1; i--) begin
      if (vec[i]) code = 4'(i);
    end
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_chk_stall_timer.sv
`default_nettype none
// ============================================================================
// Module   : axi_chk_stall_timer
// Brief    : Saturating VALID&&!READY counter with a one-shot expiry strobe.
// Revision : 1.0
// ============================================================================
module axi_chk_stall_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  input  logic i_ready,
  output logic o_expire
);

  localparam int              c_cw    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cw-1:0] c_limit = c_cw'(TIMEOUT_CYCLES);

  logic [c_cw-1:0] r_cnt;
  logic            w_stall;

  assign w_stall  = i_valid && !i_ready;
  // Strobes only on the cycle the count reaches the limit, never while parked there.
  assign o_expire = w_stall && (r_cnt == c_limit - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!w_stall) begin
      r_cnt <= '0;
    end else if (r_cnt != c_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_wr_burst_checker.sv
`default_nettype none
// ============================================================================
// Module   : axi_wr_burst_checker
// Brief    : Passive AXI write-channel monitor (WLAST placement, stalls, B
//            matching). Define AXI_WR_CHK_STABILITY_EN for payload/VALID
//            stability checks.
// Revision : 1.0
// ============================================================================
module axi_wr_burst_checker
  import axi_chk_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 128,
  parameter int LEN_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               axi_awvalid,
  input  logic                               axi_awready,
  input  logic [ADDR_WIDTH-1:0]              axi_awaddr,
  input  logic [LEN_WIDTH-1:0]               axi_awlen,
  input  logic                               axi_wvalid,
  input  logic                               axi_wready,
  input  logic                               axi_wlast,
  input  logic [DATA_WIDTH-1:0]              axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]            axi_wstrb,
  input  logic                               axi_bvalid,
  input  logic                               axi_bready,
  input  logic [1:0]                         axi_bresp,
  input  logic                               err_clr,
  output logic                               error_pulse,
  output logic [3:0]                         error_code,
  output logic                               protocol_error,
  output logic [3:0]                         first_error_code,
  output logic [15:0]                        err_count,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] aw_outstanding
);

  localparam int c_qw = $clog2(MAX_OUTSTANDING + 1);
  localparam int c_pw = $clog2(MAX_OUTSTANDING);
  localparam int c_dw = 8;

  logic [LEN_WIDTH-1:0] r_q [MAX_OUTSTANDING];
  logic [c_pw-1:0]      r_wptr, r_rptr;
  logic [c_qw-1:0]      r_q_count;
  logic [LEN_WIDTH-1:0] r_beat;
  logic [c_dw-1:0]      r_wdone;

  logic w_aw_hs, w_w_hs, w_b_hs;
  logic w_q_empty, w_q_full, w_push, w_beat_ok, w_close;
  logic [LEN_WIDTH-1:0] w_head_len;
  logic w_aw_exp, w_w_exp, w_b_exp;
  logic w_early, w_missing, w_exokay, w_orphan, w_stray, w_ovf;
  logic w_aw_chg, w_w_chg, w_drop;
  logic [ERR_MAX:1] w_err;

  axi_chk_stall_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_aw_timer (
    .clk(clk), .rst_n(rst_n), .i_valid(axi_awvalid), .i_ready(axi_awready), .o_expire(w_aw_exp));
  axi_chk_stall_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_w_timer (
    .clk(clk), .rst_n(rst_n), .i_valid(axi_wvalid), .i_ready(axi_wready), .o_expire(w_w_exp));
  axi_chk_stall_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_b_timer (
    .clk(clk), .rst_n(rst_n), .i_valid(axi_bvalid), .i_ready(axi_bready), .o_expire(w_b_exp));

  assign w_aw_hs   = axi_awvalid && axi_awready;
  assign w_w_hs    = axi_wvalid && axi_wready;
  assign w_b_hs    = axi_bvalid && axi_bready;
  assign w_q_empty = (r_q_count == '0);
  assign w_q_full  = (r_q_count == c_qw'(MAX_OUTSTANDING));
  assign w_push    = w_aw_hs && !w_q_full;

  // An AW accepted alongside a W beat on an empty queue serves as the head directly.
  assign w_head_len = w_q_empty ? axi_awlen : r_q[r_rptr];
  assign w_beat_ok  = w_w_hs && (!w_q_empty || w_aw_hs);
  assign w_early    = w_beat_ok && axi_wlast && (r_beat != w_head_len);
  assign w_missing  = w_beat_ok && !axi_wlast && (r_beat == w_head_len);
  assign w_close    = w_beat_ok && (axi_wlast || (r_beat == w_head_len));

  assign w_orphan = w_w_hs && !w_beat_ok;
  assign w_ovf    = w_aw_hs && w_q_full;
  assign w_exokay = w_b_hs && (axi_bresp == 2'b01);
  assign w_stray  = w_b_hs && (r_wdone == '0) && !w_close;

`ifdef AXI_WR_CHK_STABILITY_EN
  logic                    r_aw_stall, r_w_stall, r_b_stall;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [LEN_WIDTH-1:0]    r_awlen;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic                    r_wlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_stall <= 1'b0;
      r_w_stall  <= 1'b0;
      r_b_stall  <= 1'b0;
      r_awaddr   <= '0;
      r_awlen    <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wlast    <= 1'b0;
    end else begin
      r_aw_stall <= axi_awvalid && !axi_awready;
      r_w_stall  <= axi_wvalid && !axi_wready;
      r_b_stall  <= axi_bvalid && !axi_bready;
      if (axi_awvalid && !axi_awready) begin
        r_awaddr <= axi_awaddr;
        r_awlen  <= axi_awlen;
      end
      if (axi_wvalid && !axi_wready) begin
        r_wdata <= axi_wdata;
        r_wstrb <= axi_wstrb;
        r_wlast <= axi_wlast;
      end
    end
  end

  assign w_aw_chg = r_aw_stall && axi_awvalid && ({axi_awaddr, axi_awlen} != {r_awaddr, r_awlen});
  assign w_w_chg  = r_w_stall && axi_wvalid &&
                    ({axi_wdata, axi_wstrb, axi_wlast} != {r_wdata, r_wstrb, r_wlast});
  assign w_drop   = (r_aw_stall && !axi_awvalid) || (r_w_stall && !axi_wvalid) ||
                    (r_b_stall && !axi_bvalid);
`else
  logic w_unused_payload;
  assign w_unused_payload = ^{axi_awaddr, axi_wdata, axi_wstrb};
  assign w_aw_chg = 1'b0;
  assign w_w_chg  = 1'b0;
  assign w_drop   = 1'b0;
`endif

  assign w_err = {w_drop, w_w_chg, w_aw_chg, w_ovf, w_stray, w_orphan,
                  w_exokay, w_missing, w_early, w_b_exp, w_w_exp, w_aw_exp};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_q[i] <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_q_count <= '0;
      r_beat    <= '0;
      r_wdone   <= '0;
    end else begin
      if (w_push) begin
        r_q[r_wptr] <= axi_awlen;
        r_wptr      <= r_wptr + 1'b1;
      end
      if (w_close) begin
        r_rptr <= r_rptr + 1'b1;
        r_beat <= '0;
      end else if (w_beat_ok) begin
        r_beat <= r_beat + 1'b1;
      end
      case ({w_push, w_close})
        2'b10:   r_q_count <= r_q_count + 1'b1;
        2'b01:   r_q_count <= r_q_count - 1'b1;
        default: r_q_count <= r_q_count;
      endcase
      // A burst closing in the same cycle as a B handshake cancels out.
      if (w_close && !w_b_hs) begin
        if (r_wdone != '1) r_wdone <= r_wdone + 1'b1;
      end else if (!w_close && w_b_hs && (r_wdone != '0)) begin
        r_wdone <= r_wdone - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_pulse      <= 1'b0;
      error_code       <= ERR_NONE;
      protocol_error   <= 1'b0;
      first_error_code <= ERR_NONE;
      err_count        <= '0;
    end else begin
      error_pulse <= |w_err;
      error_code  <= err_pick(w_err);
      if (|w_err) begin
        protocol_error <= 1'b1;
        if (!protocol_error || err_clr) first_error_code <= err_pick(w_err);
        if (err_count != '1) err_count <= err_count + 1'b1;
      end else if (err_clr) begin
        protocol_error   <= 1'b0;
        first_error_code <= ERR_NONE;
      end
    end
  end

  assign aw_outstanding = r_q_count;

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_burst_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_wr_burst_checker
// Brief    : Directed + randomized bench for axi_wr_burst_checker against a
//            queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_axi_wr_burst_checker;

  localparam int MAX_OUT = 4;
  localparam int TO      = 256;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready, err_clr;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic [1:0]   bresp;
  logic         error_pulse, protocol_error;
  logic [3:0]   error_code, first_error_code;
  logic [15:0]  err_count;
  logic [2:0]   aw_outstanding;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int lenq[$];
  int beats, wdone, t_aw, t_w, t_b;
  bit m_pulse, m_perr;
  int m_code, m_first, m_cnt;

  axi_wr_burst_checker dut (
    .clk(clk), .rst_n(rst_n),
    .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr), .axi_awlen(awlen),
    .axi_wvalid(wvalid), .axi_wready(wready), .axi_wlast(wlast), .axi_wdata(wdata),
    .axi_wstrb(wstrb), .axi_bvalid(bvalid), .axi_bready(bready), .axi_bresp(bresp),
    .err_clr(err_clr), .error_pulse(error_pulse), .error_code(error_code),
    .protocol_error(protocol_error), .first_error_code(first_error_code),
    .err_count(err_count), .aw_outstanding(aw_outstanding));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    lenq.delete();
    beats = 0; wdone = 0; t_aw = 0; t_w = 0; t_b = 0;
    m_pulse = 0; m_perr = 0; m_code = 0; m_first = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit [12:0] e;
    bit        closed, full;
    int        len;
    e = '0; closed = 0;
    full = (lenq.size() >= MAX_OUT);
    if (awvalid && !awready) begin
      if (t_aw < TO) begin t_aw++; if (t_aw == TO) e[1] = 1; end
    end else t_aw = 0;
    if (wvalid && !wready) begin
      if (t_w < TO) begin t_w++; if (t_w == TO) e[2] = 1; end
    end else t_w = 0;
    if (bvalid && !bready) begin
      if (t_b < TO) begin t_b++; if (t_b == TO) e[3] = 1; end
    end else t_b = 0;
    if (wvalid && wready) begin
      if (lenq.size() == 0 && !(awvalid && awready)) e[7] = 1;
      else begin
        len = (lenq.size() != 0) ? lenq[0] : int'(awlen);
        if (wlast && beats < len)        begin e[4] = 1; closed = 1; end
        else if (!wlast && beats == len) begin e[5] = 1; closed = 1; end
        else if (wlast)                  closed = 1;
        else                             beats++;
      end
    end
    if (awvalid && awready) begin
      if (full) e[9] = 1;
      else lenq.push_back(int'(awlen));
    end
    if (closed) begin
      void'(lenq.pop_front());
      beats = 0;
      wdone++;
    end
    if (bvalid && bready) begin
      if (bresp == 2'b01) e[6] = 1;
      if (wdone == 0) e[8] = 1;
      else wdone--;
    end
    m_pulse = |e;
    m_code  = 0;
    for (int i = 12; i >= 1; i--) if (e[i]) m_code = i;
    if (m_pulse) begin
      if (!m_perr || err_clr) m_first = m_code;
      m_perr = 1;
      if (m_cnt < 65535) m_cnt++;
    end else if (err_clr) begin
      m_perr = 0; m_first = 0;
    end
  endtask

  task automatic check_all();
    chk("error_pulse", 16'(error_pulse), 16'(m_pulse));
    chk("error_code", 16'(error_code), 16'(m_code));
    chk("protocol_error", 16'(protocol_error), 16'(m_perr));
    chk("first_error_code", 16'(first_error_code), 16'(m_first));
    chk("err_count", err_count, 16'(m_cnt));
    chk("aw_outstanding", 16'(aw_outstanding), 16'(lenq.size()));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    awvalid = 0; awready = 0; wvalid = 0; wready = 0; wlast = 0;
    bvalid = 0; bready = 0; bresp = 0; err_clr = 0;
  endtask

  task automatic aw(input int len);
    awvalid = 1; awready = 1; awlen = 8'(len); awaddr = $urandom;
    step();
    awvalid = 0; awready = 0;
  endtask

  task automatic wbeat(input bit last);
    wvalid = 1; wready = 1; wlast = last;
    wdata = {$urandom, $urandom, $urandom, $urandom}; wstrb = 16'($urandom);
    step();
    wvalid = 0; wready = 0; wlast = 0;
  endtask

  task automatic bresp_hs(input logic [1:0] r);
    bvalid = 1; bready = 1; bresp = r;
    step();
    bvalid = 0; bready = 0; bresp = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    step();
    step();
    rst_n = 1;
  endtask

  initial begin
    int pulses;
    idle();
    awaddr = 0; awlen = 0; wdata = 0; wstrb = 0;
    rst_n = 1;
    model_reset();
    #2;
    do_reset();

    // Legal 4-beat burst followed by OKAY.
    aw(3);
    wbeat(0); wbeat(0); wbeat(0); wbeat(1);
    bresp_hs(2'b00);
    chk("legal_err_count", err_count, 16'd0);
    chk("legal_outstanding", 16'(aw_outstanding), 16'd0);

    // WLAST on beat 2 of a 4-beat burst.
    aw(3);
    wbeat(0); wbeat(1);
    chk("early_code", 16'(error_code), 16'd4);
    chk("early_sticky", 16'(protocol_error), 16'd1);
    chk("early_first", 16'(first_error_code), 16'd4);
    bresp_hs(2'b00);
    err_clr = 1; step(); err_clr = 0;

    // AW stall: exactly one expiry pulse at the timeout, none afterwards.
    pulses = 0;
    awvalid = 1; awready = 0; awlen = 0; awaddr = 32'h1000;
    for (int i = 1; i <= TO + 20; i++) begin
      step();
      if (error_pulse) pulses++;
      if (i == TO) chk("aw_stall_code", 16'(error_code), 16'd1);
    end
    chk("aw_stall_pulses", 16'(pulses), 16'd1);
    awready = 1; step(); awvalid = 0; awready = 0;
    wbeat(1);
    bresp_hs(2'b00);

    // Queue overflow on the fifth AW.
    err_clr = 1; step(); err_clr = 0;
    for (int i = 0; i < 5; i++) aw(0);
    chk("ovf_code", 16'(error_code), 16'd9);
    chk("ovf_outstanding", 16'(aw_outstanding), 16'd4);
    for (int i = 0; i < 4; i++) wbeat(1);
    for (int i = 0; i < 4; i++) bresp_hs(2'b00);

    // Stray B, then EXOKAY on a real burst.
    do_reset();
    bresp_hs(2'b00);
    chk("stray_code", 16'(error_code), 16'd8);
    aw(1); wbeat(0); wbeat(1);
    bresp_hs(2'b01);
    chk("exokay_code", 16'(error_code), 16'd6);
    chk("exokay_count", err_count, 16'd2);
    chk("exokay_first", 16'(first_error_code), 16'd8);

    // Same-cycle AW and W on an empty queue, then reset mid-burst.
    do_reset();
    awvalid = 1; awready = 1; awlen = 0; wvalid = 1; wready = 1; wlast = 1;
    step();
    idle();
    chk("bypass_pulse", 16'(error_pulse), 16'd0);
    bresp_hs(2'b00);
    aw(3); wbeat(0); wbeat(0);
    do_reset();
    chk("post_reset_outstanding", 16'(aw_outstanding), 16'd0);
    aw(3); wbeat(0); wbeat(0); wbeat(0); wbeat(1);
    bresp_hs(2'b00);
    chk("post_reset_clean", err_count, 16'd0);

    // Randomized traffic; payloads and VALID are held while stalled.
    for (int n = 0; n < 1500; n++) begin
      if (!(awvalid && !awready)) begin
        awvalid = 1'($urandom); awaddr = $urandom; awlen = 8'($urandom_range(0, 3));
      end
      awready = ($urandom_range(0, 2) != 0);
      if (!(wvalid && !wready)) begin
        wvalid = 1'($urandom); wlast = ($urandom_range(0, 2) == 0);
        wdata = {$urandom, $urandom, $urandom, $urandom}; wstrb = 16'($urandom);
      end
      wready = ($urandom_range(0, 2) != 0);
      if (!(bvalid && !bready)) begin
        bvalid = ($urandom_range(0, 3) == 0);
        bresp  = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      end
      bready  = ($urandom_range(0, 2) != 0);
      err_clr = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
